// File: rtl/fifo_wm.sv
// Parametrised circular-buffer FIFO with occupancy count, flush and two watermark flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_wm #(
  parameter  int DATA_SIZE = 32,
  parameter  int DEPTH     = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  input  logic [CW-1:0]        watermark_level,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 wm_above,
  output logic                 wm_below
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                 err_clear,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 clear;
  logic                 wr_acc;
  logic                 rd_acc;

  assign clear = reset | flush;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign wm_above = (count_q > watermark_level);
  assign wm_below = (count_q < watermark_level);

  // A read on a full FIFO frees the slot the concurrent write lands in.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_en);

  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clock) begin
    if (wr_acc && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clock) begin
    if (clear || err_clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow_q  <= 1'b1;
      if (rd_en && empty)   underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_wm.sv
// Self-checking bench for fifo_wm: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fifo_wm;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset, flush, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic [CW-1:0] watermark_level, count;
  logic          empty, full, wm_above, wm_below;
  logic          err_clr = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queue plus sticky error bits
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  typedef struct {
    bit          wr;
    logic [7:0]  wd;
    bit          rd;
    logic [3:0]  wm;
    int          exp_cnt;
    bit          exp_empty, exp_full, exp_above, exp_below;
    bit          dchk;
    logic [7:0]  exp_d;
  } vec_t;
  vec_t vecs[$];

  fifo_wm #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .watermark_level(watermark_level), .count(count),
    .empty(empty), .full(full), .wm_above(wm_above), .wm_below(wm_below)
`ifdef FIFO_ERR_FLAGS_EN
    , .err_clear(err_clr), .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(bit wr, logic [7:0] wd, bit rd, int wm, int cnt,
                              bit dchk, logic [7:0] d);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.wm = 4'(wm);
    v.exp_cnt   = cnt;
    v.exp_empty = (cnt == 0);
    v.exp_full  = (cnt == DEPTH);
    v.exp_above = (cnt > wm);
    v.exp_below = (cnt < wm);
    v.dchk = dchk; v.exp_d = d;
    vecs.push_back(v);
  endfunction

  function automatic void model_step(bit wr, logic [7:0] wd, bit rd, bit clr_all);
    int pre   = mq.size();
    bit rd_ok = rd && (pre > 0);
    bit wr_ok = wr && ((pre < DEPTH) || rd);
    if (clr_all) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (wr && !wr_ok) m_ovf = 1'b1;
        if (rd && pre == 0) m_unf = 1'b1;
      end
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(wd);
    end
  endfunction

  // Drive one cycle of inputs, let the edge happen, update the model, sample 1ns later.
  task automatic tick(input bit wr, input logic [7:0] wd, input bit rd, input bit fl,
                      input bit rs = 1'b0);
    wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; reset = rs;
    @(posedge clock);
    model_step(wr, wd, rd, fl | rs);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n = mq.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".above"}, 32'(wm_above), 32'(n > int'(watermark_level)));
    check({tag, ".below"}, 32'(wm_below), 32'(n < int'(watermark_level)));
    if (n > 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  initial begin
    logic [7:0] exp2 [8];
    exp2 = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hA0, 8'hA0, 8'hA0};

    // Table: fill 0x11..0x88, dropped 9th write, drain, then climb 0..5 with watermark 3
    for (int k = 1; k <= 8; k++) add(1'b1, 8'(17 * k), 1'b0, 3, k, 1'b1, 8'h11);
    add(1'b1, 8'h99, 1'b0, 3, 8, 1'b1, 8'h11);
    for (int i = 1; i <= 8; i++) add(1'b0, 8'h00, 1'b1, 3, 8 - i, (i < 8), 8'(17 * (i + 1)));
    for (int k = 1; k <= 5; k++) add(1'b1, 8'(k), 1'b0, 3, k, 1'b1, 8'h01);

    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    watermark_level = 4'd3;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset.count", 32'(count), 0);
    check("reset.empty", 32'(empty), 1);
    check("reset.full",  32'(full), 0);
    check("reset.above", 32'(wm_above), 0);
    check("reset.below", 32'(wm_below), 1);
`ifdef FIFO_ERR_FLAGS_EN
    check("reset.overflow",  32'(overflow), 0);
    check("reset.underflow", 32'(underflow), 0);
`endif

    foreach (vecs[i]) begin
      watermark_level = vecs[i].wm;
      tick(vecs[i].wr, vecs[i].wd, vecs[i].rd, 1'b0);
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d.full", i),  32'(full),  32'(vecs[i].exp_full));
      check($sformatf("vec%0d.above", i), 32'(wm_above), 32'(vecs[i].exp_above));
      check($sformatf("vec%0d.below", i), 32'(wm_below), 32'(vecs[i].exp_below));
      if (vecs[i].dchk) check($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].exp_d));
    end

    // Watermark 0 takes effect combinationally (count is 5 here)
    watermark_level = 4'd0;
    #1;
    check("wm0.below", 32'(wm_below), 0);
    check("wm0.above", 32'(wm_above), 1);
    watermark_level = 4'd3;

    // Full with simultaneous read+write
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) tick(1'b1, 8'(17 * k), 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 8'hA0, 1'b1, 1'b0);
      check("fullrw.count", 32'(count), 8);
      check("fullrw.full",  32'(full), 1);
    end
    watermark_level = 4'd8;  #1;
    check("wm8.above", 32'(wm_above), 0);
    check("wm8.below", 32'(wm_below), 0);
    watermark_level = 4'd15; #1;
    check("wm15.above", 32'(wm_above), 0);
    check("wm15.below", 32'(wm_below), 1);
    watermark_level = 4'd7;  #1;
    check("wm7.above", 32'(wm_above), 1);
    watermark_level = 4'd3;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fullrw.rd%0d", i), 32'(rd_data), 32'(exp2[i]));
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("fullrw.empty", 32'(empty), 1);

    // Empty with simultaneous read+write
    tick(1'b1, 8'h5A, 1'b1, 1'b0);
    check("emptyrw.count", 32'(count), 1);
    check("emptyrw.data",  32'(rd_data), 32'h5A);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("rdempty.count", 32'(count), 0);
    tick(1'b1, 8'h6B, 1'b0, 1'b0);
    check("rdempty.data", 32'(rd_data), 32'h6B);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush overrides a concurrent write; then wrap the pointers
    for (int k = 0; k < 4; k++) tick(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
    tick(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush.count", 32'(count), 0);
    check("flush.empty", 32'(empty), 1);
    tick(1'b1, 8'h33, 1'b0, 1'b0);
    check("flush.next_data", 32'(rd_data), 32'h33);
    check("flush.next_count", 32'(count), 1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8'(8'hC0 + i), (i >= 3), 1'b0);
      check_model("wrap");
    end
    for (int i = 0; i < 10 && mq.size() > 0; i++) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      check_model("drain");
    end
    check("drain.empty", 32'(empty), 1);

    // Reset overrides a concurrent write
    tick(1'b1, 8'h01, 1'b0, 1'b0);
    tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    check("rstwr.count", 32'(count), 0);
    check("rstwr.empty", 32'(empty), 1);

`ifdef FIFO_ERR_FLAGS_EN
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("err.underflow_set", 32'(underflow), 1);
    check("err.overflow_idle", 32'(overflow), 0);
    for (int k = 0; k < 8; k++) tick(1'b1, 8'(k), 1'b0, 1'b0);
    tick(1'b1, 8'hFF, 1'b0, 1'b0);
    check("err.overflow_set", 32'(overflow), 1);
    for (int j = 0; j < 5; j++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      check("err.hold_ovf", 32'(overflow), 1);
      check("err.hold_unf", 32'(underflow), 1);
    end
    err_clr = 1'b1;
    tick(1'b1, 8'hFF, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("err.clear_ovf", 32'(overflow), 0);
    check("err.clear_unf", 32'(underflow), 0);
    check_model("err");
`endif

    // Randomized traffic against the queue model
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) watermark_level = 4'($urandom_range(0, 15));
      err_clr = ($urandom_range(0, 29) == 0);
      tick(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 49) == 0));
      err_clr = 1'b0;
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
